// File: rtl/force_accumulator.sv
// rtl/force_accumulator.sv - sums per-node force stage streams into one net force per node/axis.
// Define FORCE_ACC_SATURATE_EN to clamp each sum; otherwise sums wrap in two's complement.
module force_accumulator #(
  parameter int NUM_NODES  = 10,
  parameter int FORCE_SIZE = 8,
  parameter int ACC_SIZE   = 12,
  parameter int NUM_STAGES = 3
) (
  input  logic                                          clk_in,
  input  logic                                          rst_in,
  input  logic                                          clear_in,
  input  logic signed [FORCE_SIZE-1:0]                  force_x_in,
  input  logic signed [FORCE_SIZE-1:0]                  force_y_in,
  input  logic                                          force_valid_in,
  input  logic                                          stage_done_in,
  output logic signed [1:0][NUM_NODES-1:0][ACC_SIZE-1:0] forces_out,
  output logic                                          result_out,
  output logic                                          busy_out,
  output logic                                          error_out
);

  localparam int IDX_W = $clog2(NUM_NODES + 1);
  localparam int STG_W = $clog2(NUM_STAGES + 1);
  localparam logic [IDX_W-1:0] IDX_FULL = IDX_W'(NUM_NODES);
  localparam logic [STG_W-1:0] STG_LAST = STG_W'(NUM_STAGES);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   node_idx, idx_after;
  logic [STG_W-1:0]   stage_cnt, stage_next;
  logic               accum, take, drop, stage_end, frame_end;

  function automatic logic [ACC_SIZE-1:0] add_force(
    input logic signed [ACC_SIZE-1:0]   acc,
    input logic signed [FORCE_SIZE-1:0] f
  );
`ifdef FORCE_ACC_SATURATE_EN
    logic signed [ACC_SIZE:0] sum;
    sum = (ACC_SIZE+1)'(acc) + (ACC_SIZE+1)'(f);
    // Top two bits disagree only when the sum left the ACC_SIZE range.
    if (sum[ACC_SIZE] != sum[ACC_SIZE-1])
      return sum[ACC_SIZE] ? {1'b1, {(ACC_SIZE-1){1'b0}}} : {1'b0, {(ACC_SIZE-1){1'b1}}};
    return sum[ACC_SIZE-1:0];
`else
    logic signed [ACC_SIZE-1:0] sum;
    sum = acc + ACC_SIZE'(f);
    return sum;
`endif
  endfunction

  always_comb begin
    accum      = (state_q == ACCUM) && !clear_in;
    take       = accum && force_valid_in && (node_idx < IDX_FULL);
    drop       = accum && force_valid_in && !(node_idx < IDX_FULL);
    idx_after  = node_idx + IDX_W'(take);
    stage_end  = accum && stage_done_in;
    stage_next = stage_cnt + STG_W'(1);
    frame_end  = stage_end && (stage_next == STG_LAST);
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    busy_out = (state_q == ACCUM);
    if (clear_in)       state_d = ACCUM;
    else if (frame_end) state_d = DONE;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      forces_out <= '0;
      node_idx   <= '0;
      stage_cnt  <= '0;
      result_out <= 1'b0;
      error_out  <= 1'b0;
    end else begin
      result_out <= frame_end;
      if (clear_in) begin
        forces_out <= '0;
        node_idx   <= '0;
        stage_cnt  <= '0;
        error_out  <= 1'b0;
      end else if (state_q == ACCUM) begin
        for (int n = 0; n < NUM_NODES; n++) begin
          if (take && (node_idx == IDX_W'(n))) begin
            forces_out[0][n] <= add_force(forces_out[0][n], force_x_in);
            forces_out[1][n] <= add_force(forces_out[1][n], force_y_in);
          end
        end
        // Short-stream check sees the index after a coincident sample.
        if (drop || (stage_end && (idx_after != IDX_FULL)))
          error_out <= 1'b1;
        if (stage_end) begin
          node_idx  <= '0;
          stage_cnt <= stage_next;
        end else begin
          node_idx  <= idx_after;
        end
      end
    end
  end

endmodule

// File: tb/tb_force_accumulator.sv
// tb/tb_force_accumulator.sv - self-checking bench for force_accumulator with a behavioural frame model.
module tb_force_accumulator;

  localparam int N    = 4;
  localparam int FW   = 8;
  localparam int AW_A = 10;
  localparam int ST_A = 2;
  localparam int AW_B = 8;
  localparam int ST_B = 3;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic rst_in;

  logic                                  clear_a, fv_a, sd_a;
  logic signed [FW-1:0]                  fx_a, fy_a;
  logic signed [1:0][N-1:0][AW_A-1:0]    forces_a;
  logic                                  result_a, busy_a, error_a;

  logic                                  clear_b, fv_b, sd_b;
  logic signed [FW-1:0]                  fx_b, fy_b;
  logic signed [1:0][N-1:0][AW_B-1:0]    forces_b;
  logic                                  result_b, busy_b, error_b;

  force_accumulator #(.NUM_NODES(N), .FORCE_SIZE(FW), .ACC_SIZE(AW_A), .NUM_STAGES(ST_A)) dut_a (
    .clk_in(clk_in), .rst_in(rst_in), .clear_in(clear_a),
    .force_x_in(fx_a), .force_y_in(fy_a), .force_valid_in(fv_a), .stage_done_in(sd_a),
    .forces_out(forces_a), .result_out(result_a), .busy_out(busy_a), .error_out(error_a)
  );

  force_accumulator #(.NUM_NODES(N), .FORCE_SIZE(FW), .ACC_SIZE(AW_B), .NUM_STAGES(ST_B)) dut_b (
    .clk_in(clk_in), .rst_in(rst_in), .clear_in(clear_b),
    .force_x_in(fx_b), .force_y_in(fy_b), .force_valid_in(fv_b), .stage_done_in(sd_b),
    .forces_out(forces_b), .result_out(result_b), .busy_out(busy_b), .error_out(error_b)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model of instance A: frame-level view of net forces
  int ma [2][N];
  int a_idx, a_stage, a_pulses;
  bit a_armed, a_err, a_res;

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int reduce(input int v, input int w);
    int lo, hi, span, r;
    lo   = -(1 << (w - 1));
    hi   = (1 << (w - 1)) - 1;
    span = 1 << w;
`ifdef FORCE_ACC_SATURATE_EN
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
`else
    r = (v - lo) % span;
    if (r < 0) r += span;
    return r + lo;
`endif
  endfunction

  task automatic tick_a();
    @(posedge clk_in);
    #1;
    if (result_a === 1'b1) a_pulses++;
    chk("result_a", int'(result_a), int'(a_res));
    chk("busy_a", int'(busy_a), int'(a_armed));
    chk("error_a", int'(error_a), int'(a_err));
    a_res = 1'b0;
  endtask

  task automatic model_reset();
    foreach (ma[a, n]) ma[a][n] = 0;
    a_idx = 0; a_stage = 0; a_armed = 0; a_err = 0; a_res = 0;
  endtask

  task automatic send_a(input int x, input int y, input bit valid, input bit done);
    fx_a = FW'(x); fy_a = FW'(y); fv_a = valid; sd_a = done;
    if (a_armed) begin
      if (valid) begin
        if (a_idx < N) begin
          ma[0][a_idx] = reduce(ma[0][a_idx] + x, AW_A);
          ma[1][a_idx] = reduce(ma[1][a_idx] + y, AW_A);
          a_idx++;
        end else begin
          a_err = 1;
        end
      end
      if (done) begin
        if (a_idx != N) a_err = 1;
        a_idx = 0;
        a_stage++;
        if (a_stage == ST_A) begin
          a_armed = 0;
          a_res = 1;
        end
      end
    end
    tick_a();
    fv_a = 0; sd_a = 0;
  endtask

  task automatic clear_frame_a();
    // Coincident valid/done must be ignored by clear.
    clear_a = 1; fv_a = 1; sd_a = 1; fx_a = 8'sd55; fy_a = 8'sd55;
    foreach (ma[a, n]) ma[a][n] = 0;
    a_idx = 0; a_stage = 0; a_armed = 1; a_err = 0; a_res = 0;
    tick_a();
    clear_a = 0; fv_a = 0; sd_a = 0;
  endtask

  task automatic check_forces_a(input string tag);
    for (int n = 0; n < N; n++) begin
      chk($sformatf("%s x%0d", tag, n), int'($signed(forces_a[0][n])), ma[0][n]);
      chk($sformatf("%s y%0d", tag, n), int'($signed(forces_a[1][n])), ma[1][n]);
    end
  endtask

  initial begin
    int len;
    bit joined;
    rst_in = 0;
    clear_a = 0; fv_a = 0; sd_a = 0; fx_a = '0; fy_a = '0;
    clear_b = 0; fv_b = 0; sd_b = 0; fx_b = '0; fy_b = '0;
    a_pulses = 0;
    model_reset();

    repeat (2) @(posedge clk_in);
    #1;
    check_forces_a("por");
    chk("por busy", int'(busy_a), 0);
    chk("por result", int'(result_a), 0);
    chk("por error", int'(error_a), 0);
    rst_in = 1;

    // Reset mid-ACCUM after two samples; later valids ignored until clear.
    clear_frame_a();
    send_a(9, -9, 1, 0);
    send_a(8, -8, 1, 0);
    rst_in = 0;
    #2;
    model_reset();
    check_forces_a("rst");
    chk("rst busy", int'(busy_a), 0);
    chk("rst error", int'(error_a), 0);
    chk("rst result", int'(result_a), 0);
    tick_a();
    rst_in = 1;
    send_a(3, 3, 1, 0);
    send_a(3, 3, 1, 1);
    check_forces_a("idle ignore");

    // Nominal frame
    clear_frame_a();
    for (int n = 0; n < N; n++) send_a(n + 1, -1, 1, 0);
    send_a(0, 0, 0, 1);
    for (int n = 0; n < N; n++) send_a(10, 5, 1, 0);
    send_a(0, 0, 0, 1);
    check_forces_a("nominal");
    chk("nominal x0 const", int'($signed(forces_a[0][0])), 11);
    chk("nominal y3 const", int'($signed(forces_a[1][3])), 4);
    send_a(1, 1, 1, 1);
    send_a(0, 0, 0, 0);
    check_forces_a("done hold");

    // Short stream
    clear_frame_a();
    for (int n = 0; n < 3; n++) send_a(20, 21, 1, 0);
    send_a(0, 0, 0, 1);
    chk("short node3 x", int'($signed(forces_a[0][3])), 0);
    for (int n = 0; n < N; n++) send_a(1, 2, 1, 0);
    send_a(0, 0, 0, 1);
    check_forces_a("short");

    // Overflow stream
    clear_frame_a();
    for (int n = 0; n < 5; n++) send_a(30 + n, -n, 1, 0);
    send_a(0, 0, 0, 1);
    for (int n = 0; n < N; n++) send_a(-1, -1, 1, 0);
    send_a(0, 0, 0, 1);
    check_forces_a("overflow");

    // Last sample together with stage done
    clear_frame_a();
    for (int s = 0; s < ST_A; s++)
      for (int n = 0; n < N; n++) send_a(40 + n, -40, 1, n == N - 1);
    check_forces_a("joined");

    // Clear mid-frame
    clear_frame_a();
    for (int n = 0; n < N; n++) send_a(50, 50, 1, 0);
    send_a(0, 0, 0, 1);
    a_pulses = 0;
    clear_frame_a();
    for (int s = 0; s < ST_A; s++) begin
      for (int n = 0; n < N; n++) send_a(7, 0, 1, 0);
      send_a(0, 0, 0, 1);
    end
    repeat (3) send_a(0, 0, 0, 0);
    check_forces_a("midclear");
    chk("midclear x2 const", int'($signed(forces_a[0][2])), 14);
    chk("midclear pulses", a_pulses, 1);

    // Randomized frames with random stream lengths
    for (int f = 0; f < 6; f++) begin
      clear_frame_a();
      for (int s = 0; s < ST_A; s++) begin
        len = int'($urandom_range(5, 3));
        joined = 1'($urandom_range(1, 0));
        for (int k = 0; k < len; k++)
          send_a(int'($urandom_range(255, 0)) - 128, int'($urandom_range(255, 0)) - 128,
                 1, joined && (k == len - 1));
        if (!joined) send_a(0, 0, 0, 1);
      end
      check_forces_a($sformatf("rand%0d", f));
    end

    // Narrow accumulator: saturate or wrap
    clear_b = 1;
    @(posedge clk_in); #1;
    clear_b = 0;
    chk("b busy", int'(busy_b), 1);
    for (int s = 0; s < ST_B; s++) begin
      for (int n = 0; n < N; n++) begin
        fv_b = 1; fx_b = 8'sd100; fy_b = -8'sd100;
        @(posedge clk_in); #1;
      end
      fv_b = 0; sd_b = 1;
      @(posedge clk_in); #1;
      sd_b = 0;
    end
    chk("b result", int'(result_b), 1);
    chk("b busy done", int'(busy_b), 0);
    chk("b error", int'(error_b), 0);
    for (int n = 0; n < N; n++) begin
`ifdef FORCE_ACC_SATURATE_EN
      chk($sformatf("b x%0d", n), int'($signed(forces_b[0][n])), 127);
      chk($sformatf("b y%0d", n), int'($signed(forces_b[1][n])), -128);
`else
      chk($sformatf("b x%0d", n), int'($signed(forces_b[0][n])), 44);
      chk($sformatf("b y%0d", n), int'($signed(forces_b[1][n])), -44);
`endif
    end
    @(posedge clk_in); #1;
    chk("b result drop", int'(result_b), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/force_accumulator.md
Name: force_accumulator

Overview:
- Sits directly downstream of the torque stage and the other per-node force stages (spring, pressure, gravity) in the soft-body update loop.
- Consumes their in-order per-node force streams and sums them into one net force per node, per axis.
- Publishes the net-force array and a one-cycle result pulse to the integrator once every stage of the frame has finished.

Parameters:
NUM_NODES, 10, nodes per stream; a stream is node 0 to NUM_NODES-1 in order
FORCE_SIZE, 8, signed width of incoming force components
ACC_SIZE, 12, signed width of each accumulator; must be >= FORCE_SIZE
NUM_STAGES, 3, number of force stages summed per frame

Ports:
clk_in  input  1  system clock
rst_in  input  1  asynchronous reset, active-low
clear_in  input  1  frame start; zeroes accumulators and arms the block
force_x_in  input  FORCE_SIZE signed  x force for the current node
force_y_in  input  FORCE_SIZE signed  y force for the current node
force_valid_in  input  1  force_x_in/force_y_in valid this cycle
stage_done_in  input  1  one-cycle pulse; the current stage's stream has ended
forces_out  output  [1:0][NUM_NODES] x ACC_SIZE signed  net forces; index 0 = x, 1 = y
result_out  output  1  one-cycle pulse; forces_out is final
busy_out  output  1  high while in ACCUM
error_out  output  1  sticky stream-length error; cleared by clear_in or reset

Behaviour:
- States: IDLE, ACCUM, DONE.
- Reset (rst_in low, async):
  - State goes to IDLE.
  - All accumulators (forces_out) are 0.
  - node_idx, stage_cnt, result_out, busy_out and error_out are 0.
- clear_in (any state, highest priority after reset):
  - Next cycle all accumulators, node_idx, stage_cnt and error_out are 0; state is ACCUM; busy_out is 1.
  - force_valid_in and stage_done_in in the same cycle are ignored.
- ACCUM, force_valid_in=1 and node_idx < NUM_NODES:
  - acc_x[node_idx] <= acc_x + sext(force_x_in); acc_y likewise.
  - node_idx increments. Latency is 1 cycle.
- ACCUM, force_valid_in=1 and node_idx == NUM_NODES: the sample is dropped and error_out is set to 1 (overflow).
- ACCUM, stage_done_in=1:
  - If node_idx != NUM_NODES, error_out is set to 1 (short stream).
  - node_idx resets to 0 and stage_cnt increments.
  - When the incremented stage_cnt == NUM_STAGES: state goes to DONE, busy_out goes to 0, and result_out is 1 for exactly the next cycle.
- ACCUM, force_valid_in and stage_done_in in the same cycle: the sample is applied to the current node_idx first, and the short-stream check uses the post-increment index. Then the stage-done processing above applies.
- IDLE/DONE: force_valid_in and stage_done_in are ignored with no error.
  - forces_out holds its values until the next clear_in.
  - DONE stays in DONE until clear_in.
- Arithmetic:
  - sext extends the FORCE_SIZE input to ACC_SIZE+1 bits before the add.
  - The result is reduced to ACC_SIZE bits per the optional feature.
- result_out never asserts twice per frame; it is 0 in every cycle other than the DONE-entry pulse.

Optional Feature:
- Macro: FORCE_ACC_SATURATE_EN.
- Defined: each sum clamps to [-2^(ACC_SIZE-1), 2^(ACC_SIZE-1)-1].
- Undefined: the sum wraps, two's complement, keeping the low ACC_SIZE bits.

Test Plan (NUM_NODES=4, FORCE_SIZE=8, ACC_SIZE=10, NUM_STAGES=2 unless noted):
- Reset:
  - Stimulus: rst_in low mid-ACCUM after 2 samples, then high.
  - Response: forces_out all 0, busy_out=0, error_out=0, result_out=0; valids are ignored until clear_in.
- Nominal:
  - Stimulus: clear_in; stage 0 x=1,2,3,4, y=-1,-1,-1,-1, then done; stage 1 x=10 each, y=5 each, then done.
  - Response: x=11,12,13,14; y=4,4,4,4; result_out high exactly 1 cycle after the second done; error_out=0.
- Saturation/wrap (ACC_SIZE=8, NUM_STAGES=3):
  - Stimulus: three stages of x=100, y=-100 on every node.
  - Response with FORCE_ACC_SATURATE_EN: x=127, y=-128.
  - Response without it: x=44, y=-44.
- Stream errors:
  - Stimulus A: 3 valids then done. Response A: error_out=1 and node 3 unchanged.
  - Stimulus B: 5 valids. Response B: 5th sample dropped and error_out=1.
  - The frame still completes after NUM_STAGES dones in both cases.
- Simultaneous valid+done:
  - Stimulus: the 4th sample arrives in the same cycle as stage_done_in.
  - Response: the sample is accumulated into node 3 and error_out stays 0.
- Clear mid-frame:
  - Stimulus: clear_in after stage 0, then a full 2-stage frame of x=7.
  - Response: x=14 on all nodes (stage-0 data discarded) and exactly one result_out pulse.
